fifo_control: RTL

Pointer/flag controller that sits directly upstream of the FIFO memory array. It accepts push/pop requests from the producer and consumer and drives the memory's wr_ptr and rd_ptr. It keeps an occupancy count and generates full/empty, almost-full/almost-empty, overflow/underflow and read-valid signals. It pairs with the synchronous-read memory to form a complete FIFO.

---
 rtl/fifo_control_if.sv | 28 ++
 rtl/fifo_control.sv | 56 +++++
 2 files changed

// File: rtl/fifo_control_if.sv
// fifo_control_if: push/pop requests plus the pointer, enable and status
// signals exchanged between a FIFO controller and its producer/consumer/memory.
interface fifo_control_if #(parameter int ADDR_WIDTH = 8);
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  valid_out;
    logic                  overflow;
    logic                  underflow;
    modport master (
        output push, pop,
        input  wr_ptr, rd_ptr, wr_en, rd_en, count, full, empty,
               almost_full, almost_empty, valid_out, overflow, underflow
    );
    modport slave (
        input  push, pop,
        output wr_ptr, rd_ptr, wr_en, rd_en, count, full, empty,
               almost_full, almost_empty, valid_out, overflow, underflow
    );
endinterface

// File: rtl/fifo_control.sv
// fifo_control: pointer, occupancy and status-flag controller for a synchronous-read FIFO memory.
module fifo_control #(
    parameter int ADDR_WIDTH = 8,
    parameter int AF_THRESH  = 254,
    parameter int AE_THRESH  = 2
) (
    input logic           clk,
    input logic           reset_L,
    fifo_control_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] depth  = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] af_lvl = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] ae_lvl = (ADDR_WIDTH+1)'(AE_THRESH);
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   count, count_nxt;
    logic                  full, empty, wr_en, rd_en;
    logic                  valid_out, overflow, underflow;
    // Flags decode only the registered count; reset_L gates the enables so nothing is accepted while in reset
    always_comb begin
        full      = count == depth;
        empty     = count == '0;
        wr_en     = reset_L & bus.push & ~full;
        rd_en     = reset_L & bus.pop & ~empty;
        count_nxt = (wr_en & ~rd_en) ? count + (ADDR_WIDTH+1)'(1) :
                    (rd_en & ~wr_en) ? count - (ADDR_WIDTH+1)'(1) : count;
    end
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_en ? wr_ptr + ADDR_WIDTH'(1) : wr_ptr;
            rd_ptr    <= rd_en ? rd_ptr + ADDR_WIDTH'(1) : rd_ptr;
            count     <= count_nxt;
            valid_out <= rd_en;
            overflow  <= bus.push & full;
            underflow <= bus.pop & empty;
        end
    end
    assign bus.wr_ptr       = wr_ptr;
    assign bus.rd_ptr       = rd_ptr;
    assign bus.wr_en        = wr_en;
    assign bus.rd_en        = rd_en;
    assign bus.count        = count;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = count >= af_lvl;
    assign bus.almost_empty = count <= ae_lvl;
    assign bus.valid_out    = valid_out;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;
endmodule
